// File: rtl/gpio_bram_arbiter_pkg.sv
// Shared definitions for the GPIO register-file arbiter: FSM encoding,
// requester ids and the read-latency counter width.
package gpio_bram_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } arb_state_t;

  localparam logic REQ_M0 = 1'b0;
  localparam logic REQ_M1 = 1'b1;

  localparam int unsigned LAT_CNT_W = 4;

endpackage

// File: rtl/gpio_rr_arb2.sv
// Two-way round-robin pick: a lone request wins outright, a tie goes to the
// requester that was not granted last.
module gpio_rr_arb2
  import gpio_bram_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic       gnt_valid,
  output logic       gnt_id
);

  always_comb begin
    gnt_valid = |req;
    case (req)
      2'b01:   gnt_id = REQ_M0;
      2'b10:   gnt_id = REQ_M1;
      2'b11:   gnt_id = ~last_gnt;
      default: gnt_id = REQ_M0;
    endcase
  end

endmodule

// File: rtl/gpio_bram_arbiter.sv
// Serialises two requesters onto one register-file port: one-cycle strobes,
// fixed read latency, one-cycle ack carrying the captured read data.
module gpio_bram_arbiter
  import gpio_bram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_aresetn,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wr_data,
  output logic                  m0_ack,
  output logic [DATA_WIDTH-1:0] m0_rd_data,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wr_data,
  output logic                  m1_ack,
  output logic [DATA_WIDTH-1:0] m1_rd_data,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_wr_data,
  input  logic [DATA_WIDTH-1:0] bram_rd_data,
  output logic                  bram_en,
  output logic                  bram_we,
  output logic                  bram_re,
  output logic                  busy,
  output logic                  gnt_id
);

  localparam logic [LAT_CNT_W-1:0] LAT_INIT = LAT_CNT_W'(RD_LATENCY - 1);

  if (RD_LATENCY < 1 || RD_LATENCY > 15) begin : g_bad_latency
    $error("gpio_bram_arbiter: RD_LATENCY must be within 1..15");
  end

  arb_state_t             state;
  logic                   last_gnt;
  logic                   cur_we;
  logic [LAT_CNT_W-1:0]   lat_cnt;
  logic                   gnt_valid;
  logic                   pick_id;
  logic                   sel_we;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [DATA_WIDTH-1:0]  sel_wdata;

  gpio_rr_arb2 u_rr (
    .req       ({m1_req, m0_req}),
    .last_gnt  (last_gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (pick_id)
  );

  always_comb begin
    sel_we    = m0_we;
    sel_addr  = m0_addr;
    sel_wdata = m0_wr_data;
    if (pick_id == REQ_M1) begin
      sel_we    = m1_we;
      sel_addr  = m1_addr;
      sel_wdata = m1_wr_data;
    end
  end

  // Strobes and acks are single-cycle pulses: cleared every cycle unless
  // the current state explicitly raises them for the next one.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state        <= IDLE;
      last_gnt     <= REQ_M1;
      cur_we       <= 1'b0;
      lat_cnt      <= '0;
      gnt_id       <= REQ_M0;
      busy         <= 1'b0;
      bram_addr    <= '0;
      bram_wr_data <= '0;
      bram_en      <= 1'b0;
      bram_we      <= 1'b0;
      bram_re      <= 1'b0;
      m0_ack       <= 1'b0;
      m1_ack       <= 1'b0;
      m0_rd_data   <= '0;
      m1_rd_data   <= '0;
    end else begin
      bram_en <= 1'b0;
      bram_we <= 1'b0;
      bram_re <= 1'b0;
      m0_ack  <= 1'b0;
      m1_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            gnt_id       <= pick_id;
            last_gnt     <= pick_id;
            cur_we       <= sel_we;
            bram_addr    <= sel_addr;
            bram_wr_data <= sel_wdata;
            bram_en      <= 1'b1;
            bram_we      <= sel_we;
            bram_re      <= ~sel_we;
            busy         <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          if (cur_we) begin
            if (gnt_id == REQ_M1) m1_ack <= 1'b1;
            else                  m0_ack <= 1'b1;
            state <= ACK;
          end else begin
            lat_cnt <= LAT_INIT;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt != '0) begin
            lat_cnt <= lat_cnt - 1'b1;
          end else begin
            if (gnt_id == REQ_M1) begin
              m1_rd_data <= bram_rd_data;
              m1_ack     <= 1'b1;
            end else begin
              m0_rd_data <= bram_rd_data;
              m0_ack     <= 1'b1;
            end
            state <= ACK;
          end
        end
        ACK: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_strobe_excl: assert property (@(posedge s_axi_aclk) disable iff (!s_axi_aresetn)
                                  !(bram_we && bram_re))
    else $error("gpio_bram_arbiter: bram_we and bram_re asserted together");

endmodule

// File: tb/tb_gpio_bram_arbiter.sv
// Bench for gpio_bram_arbiter: two instances (read latency 1 and 3) driven by
// directed and random requesters, checked every cycle against a timeline model.
module tb_gpio_bram_arbiter;

  logic clk = 1'b0;
  logic rst_n;

  logic        req  [2][2];
  logic        we   [2][2];
  logic        ack  [2][2];
  logic [31:0] addr [2][2];
  logic [31:0] wdat [2][2];
  logic [31:0] rdd  [2][2];
  logic [31:0] b_addr [2];
  logic [31:0] b_wd   [2];
  logic [31:0] b_rd   [2];
  logic        b_en [2];
  logic        b_we [2];
  logic        b_re [2];
  logic        busy [2];
  logic        gid  [2];

  always #5 clk = ~clk;

  gpio_bram_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RD_LATENCY(1)) dut_l1 (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
    .m0_req(req[0][0]), .m0_we(we[0][0]), .m0_addr(addr[0][0]), .m0_wr_data(wdat[0][0]),
    .m0_ack(ack[0][0]), .m0_rd_data(rdd[0][0]),
    .m1_req(req[0][1]), .m1_we(we[0][1]), .m1_addr(addr[0][1]), .m1_wr_data(wdat[0][1]),
    .m1_ack(ack[0][1]), .m1_rd_data(rdd[0][1]),
    .bram_addr(b_addr[0]), .bram_wr_data(b_wd[0]), .bram_rd_data(b_rd[0]),
    .bram_en(b_en[0]), .bram_we(b_we[0]), .bram_re(b_re[0]),
    .busy(busy[0]), .gnt_id(gid[0])
  );

  gpio_bram_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RD_LATENCY(3)) dut_l3 (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
    .m0_req(req[1][0]), .m0_we(we[1][0]), .m0_addr(addr[1][0]), .m0_wr_data(wdat[1][0]),
    .m0_ack(ack[1][0]), .m0_rd_data(rdd[1][0]),
    .m1_req(req[1][1]), .m1_we(we[1][1]), .m1_addr(addr[1][1]), .m1_wr_data(wdat[1][1]),
    .m1_ack(ack[1][1]), .m1_rd_data(rdd[1][1]),
    .bram_addr(b_addr[1]), .bram_wr_data(b_wd[1]), .bram_rd_data(b_rd[1]),
    .bram_en(b_en[1]), .bram_we(b_we[1]), .bram_re(b_re[1]),
    .busy(busy[1]), .gnt_id(gid[1])
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit rand_en = 0;

  // environment: register file seen through the DUT port
  logic [31:0] env_mem [2][16];
  bit          due_v   [2][32];
  logic [31:0] due_d   [2][32];

  // reference model: transaction timeline per instance
  logic [31:0] ref_mem [2][16];
  bit          act [2];
  int          t0 [2];
  int          te [2];
  bit          mg [2];
  bit          mwe [2];
  logic [31:0] mrdv [2];
  bit          last_g [2];
  bit          e_gnt [2];
  logic [31:0] e_addr [2];
  logic [31:0] e_wdata [2];
  logic [31:0] e_rd [2][2];

  // requesters and observation records
  int          auto_cnt [2][2];
  bit          a_we [2][2];
  logic [31:0] a_addr [2][2];
  logic [31:0] a_data [2][2];
  bit          drop [2][2];
  int          age [2][2];
  int          raise_cyc [2][2];
  int          ack_cyc [2][2];
  int          ack_cnt [2][2];
  int          re_cyc [2];
  logic [31:0] re_addr [2];
  int          we_cyc [2];
  int          we_cnt [2];
  int          idle_cnt [2];
  bit          glog [2][$];

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string nm, input int d, input logic [31:0] act_v, input logic [31:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s (lat%0d, cycle %0d): got %h expected %h", nm, lat(d), cyc, act_v, exp_v);
    end
  endtask

  task automatic clear_requesters();
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < 2; r++) begin
        req[d][r] = 1'b0; auto_cnt[d][r] = 0; drop[d][r] = 0; age[d][r] = 0;
      end
      for (int s = 0; s < 32; s++) due_v[d][s] = 0;
    end
  endtask

  task automatic cyc_begin();
    @(posedge clk);
    #1;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < 2; r++) begin
        if (drop[d][r]) begin
          req[d][r] = 1'b0;
          drop[d][r] = 0;
        end else if (!req[d][r] && rst_n &&
                     (auto_cnt[d][r] > 0 || (rand_en && $urandom_range(99) < 40))) begin
          req[d][r] = 1'b1;
          raise_cyc[d][r] = cyc;
          if (auto_cnt[d][r] > 0) begin
            we[d][r] = a_we[d][r]; addr[d][r] = a_addr[d][r]; wdat[d][r] = a_data[d][r];
            auto_cnt[d][r]--;
          end else begin
            we[d][r] = 1'($urandom_range(1));
            addr[d][r] = 32'($urandom_range(15)) << 2;
            wdat[d][r] = $urandom;
          end
        end
      end
      // only the exact latency slot carries valid data; all other cycles are noise
      if (due_v[d][cyc % 32]) begin
        b_rd[d] = due_d[d][cyc % 32];
        due_v[d][cyc % 32] = 0;
      end else begin
        b_rd[d] = $urandom;
      end
    end
  endtask

  task automatic model_step(input int d);
    bit xb, xs, xa, g;
    int idx;
    if (!rst_n) begin
      act[d] = 0; last_g[d] = 1; e_gnt[d] = 0; e_addr[d] = '0; e_wdata[d] = '0;
      e_rd[d][0] = '0; e_rd[d][1] = '0;
    end else if (act[d] && cyc == te[d] && !mwe[d]) begin
      e_rd[d][mg[d]] = mrdv[d];
    end
    xb = act[d] && cyc > t0[d] && cyc <= te[d];
    xs = act[d] && cyc == t0[d] + 1;
    xa = act[d] && cyc == te[d];
    chk("busy", d, busy[d], xb);
    chk("bram_en", d, b_en[d], xs);
    chk("bram_we", d, b_we[d], xs && mwe[d]);
    chk("bram_re", d, b_re[d], xs && !mwe[d]);
    chk("m0_ack", d, ack[d][0], xa && !mg[d]);
    chk("m1_ack", d, ack[d][1], xa && mg[d]);
    chk("gnt_id", d, gid[d], e_gnt[d]);
    chk("bram_addr", d, b_addr[d], e_addr[d]);
    chk("bram_wr_data", d, b_wd[d], e_wdata[d]);
    chk("m0_rd_data", d, rdd[d][0], e_rd[d][0]);
    chk("m1_rd_data", d, rdd[d][1], e_rd[d][1]);
    if (!rst_n) return;
    if (act[d] && cyc == te[d]) begin
      act[d] = 0;
    end else if (!act[d] && (req[d][0] || req[d][1])) begin
      g = (req[d][0] && req[d][1]) ? !last_g[d] : req[d][1];
      last_g[d] = g; e_gnt[d] = g; mg[d] = g; mwe[d] = we[d][g];
      e_addr[d] = addr[d][g]; e_wdata[d] = wdat[d][g];
      idx = int'(addr[d][g][5:2]);
      if (mwe[d]) ref_mem[d][idx] = wdat[d][g];
      else        mrdv[d] = ref_mem[d][idx];
      t0[d] = cyc;
      te[d] = mwe[d] ? cyc + 2 : cyc + lat(d) + 2;
      act[d] = 1;
    end
  endtask

  task automatic cyc_end();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      model_step(d);
      if (rst_n) begin
        if (b_we[d]) begin
          env_mem[d][b_addr[d][5:2]] = b_wd[d];
          we_cyc[d] = cyc; we_cnt[d]++;
        end
        if (b_re[d]) begin
          due_v[d][(cyc + lat(d)) % 32] = 1;
          due_d[d][(cyc + lat(d)) % 32] = env_mem[d][b_addr[d][5:2]];
          re_cyc[d] = cyc; re_addr[d] = b_addr[d];
        end
        if (b_en[d]) glog[d].push_back(gid[d]);
        if (!busy[d]) idle_cnt[d]++;
      end
      for (int r = 0; r < 2; r++) begin
        if (ack[d][r]) begin
          ack_cyc[d][r] = cyc; ack_cnt[d][r]++;
          if (req[d][r]) drop[d][r] = 1;
        end
        if (req[d][r]) begin
          age[d][r]++;
          if (age[d][r] == 60) begin
            checks++; errors++;
            $display("FAIL req_timeout (lat%0d, m%0d): request unacknowledged for 60 cycles", lat(d), r);
          end
        end else begin
          age[d][r] = 0;
        end
      end
    end
  endtask

  function automatic bit pending();
    bit p = 0;
    for (int d = 0; d < 2; d++)
      for (int r = 0; r < 2; r++)
        if (req[d][r] || auto_cnt[d][r] > 0) p = 1;
    return p || act[0] || act[1];
  endfunction

  task automatic wait_quiet(input int budget);
    int n = 0;
    do begin
      cyc_begin(); cyc_end(); n++;
    end while (pending() && n < budget);
    if (pending()) begin
      checks++; errors++;
      $display("FAIL quiet_timeout: traffic still pending after %0d cycles", budget);
    end
  endtask

  task automatic setup(input int r, input bit w, input logic [31:0] a, input logic [31:0] dt);
    for (int d = 0; d < 2; d++) begin
      auto_cnt[d][r] = 1; a_we[d][r] = w; a_addr[d][r] = a; a_data[d][r] = dt;
    end
  endtask

  task automatic tie_reads();
    setup(0, 0, 32'h20, '0);
    setup(1, 0, 32'h24, '0);
    wait_quiet(40);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [3:0] ord;
    int base;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < 2; r++) begin
        we[d][r] = 0; addr[d][r] = '0; wdat[d][r] = '0; ack_cnt[d][r] = 0;
      end
      b_rd[d] = '0;
      for (int i = 0; i < 16; i++) begin
        env_mem[d][i] = $urandom; ref_mem[d][i] = env_mem[d][i];
      end
      env_mem[d][4] = 32'hA5A50001; ref_mem[d][4] = 32'hA5A50001;
      env_mem[d][8] = 32'h20202020; ref_mem[d][8] = 32'h20202020;
      env_mem[d][9] = 32'h24242424; ref_mem[d][9] = 32'h24242424;
    end
    clear_requesters();
    repeat (3) begin cyc_begin(); cyc_end(); end
    cyc_begin(); rst_n = 1'b1; cyc_end();

    // simultaneous requests, twice: m0 wins the first tie after reset
    for (int d = 0; d < 2; d++) glog[d].delete();
    tie_reads();
    tie_reads();
    for (int d = 0; d < 2; d++) begin
      ord = '0;
      for (int k = 0; k < glog[d].size() && k < 4; k++) ord[3-k] = glog[d][k];
      chk("tie_count", d, glog[d].size(), 4);
      chk("tie_order", d, ord, 4'b0101);
      chk("tie_m0_data", d, rdd[d][0], 32'h20202020);
      chk("tie_m1_data", d, rdd[d][1], 32'h24242424);
    end

    // single m0 read at 0x10
    for (int d = 0; d < 2; d++) base = ack_cnt[d][1];
    setup(0, 0, 32'h10, '0);
    wait_quiet(40);
    for (int d = 0; d < 2; d++) begin
      chk("rd_strobe_cycle", d, re_cyc[d] - raise_cyc[d][0], 1);
      chk("rd_strobe_addr", d, re_addr[d], 32'h10);
      chk("rd_ack_cycle", d, ack_cyc[d][0] - raise_cyc[d][0], lat(d) + 2);
      chk("rd_data", d, rdd[d][0], 32'hA5A50001);
      chk("rd_no_m1_ack", d, ack_cnt[d][1], 2);
    end

    // single m1 write 0xFF to 0x04
    setup(1, 1, 32'h04, 32'h0000_00FF);
    wait_quiet(40);
    for (int d = 0; d < 2; d++) begin
      chk("wr_strobe_cycle", d, we_cyc[d] - raise_cyc[d][1], 1);
      chk("wr_ack_cycle", d, ack_cyc[d][1] - raise_cyc[d][1], 2);
      chk("wr_mem_word", d, env_mem[d][1], 32'h0000_00FF);
      chk("wr_m1_rd_kept", d, rdd[d][1], 32'h24242424);
    end

    // four back-to-back m0 writes
    for (int d = 0; d < 2; d++) begin
      auto_cnt[d][0] = 4; a_we[d][0] = 1; a_addr[d][0] = 32'h08; a_data[d][0] = 32'h1234_5678;
      we_cnt[d] = 0; idle_cnt[d] = 0;
    end
    base = cyc + 1;
    wait_quiet(60);
    for (int d = 0; d < 2; d++) begin
      chk("b2b_we_count", d, we_cnt[d], 4);
      chk("b2b_idle_cycles", d, idle_cnt[d], 8);
      chk("b2b_last_ack", d, ack_cyc[d][0] - base, 14);
    end

    // reset asserted while an m1 read sits in WAIT
    setup(1, 0, 32'h30, '0);
    for (int i = 0; i < 8; i++) begin
      cyc_begin();
      if (i == 2) begin rst_n = 1'b0; clear_requesters(); end
      if (i == 4) rst_n = 1'b1;
      cyc_end();
    end
    for (int d = 0; d < 2; d++) begin
      chk("rst_no_m1_ack", d, ack_cnt[d][1], 3);
      glog[d].delete();
    end
    tie_reads();
    for (int d = 0; d < 2; d++) chk("rst_first_tie_m0", d, glog[d].size() > 0 ? glog[d][0] : 1'b1, 1'b0);

    // randomized traffic
    rand_en = 1;
    repeat (2000) begin cyc_begin(); cyc_end(); end
    rand_en = 0;
    wait_quiet(100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
